// File: rtl/viterbi_pkg.sv
// Shared definitions for the hard-decision Viterbi decoder blocks.
// Used by the frame controller, the enable pipe, and the BMU/ACS/traceback.
package viterbi_pkg;

    localparam int SYM_W       = 2;
    localparam int LEN_W_DEF   = 8;
    localparam int ACS_LAT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        TRACE,
        FIN
    } state_t;

endpackage

// File: rtl/viterbi_en_pipe.sv
// Delay line carrying {valid, symbol index} from the BMU load enable
// to the ACS enable and the survivor-memory write port.
module viterbi_en_pipe
    import viterbi_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int ACS_LAT = ACS_LAT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [LEN_W-1:0] in_idx,
    output logic             acs_en,
    output logic             sm_wr_en,
    output logic [LEN_W-1:0] sm_wr_addr
);

    localparam int DEPTH = ACS_LAT + 1;

    logic [DEPTH-1:0] vld_q;
    logic [LEN_W-1:0] idx_q [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                idx_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            idx_q[0] <= in_idx;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                idx_q[k] <= idx_q[k-1];
            end
        end
    end

    // The ACS sees branch metrics ACS_LAT cycles after the load; the write lands one cycle later.
    generate
        if (ACS_LAT == 0) begin : g_lat0
            assign acs_en = in_valid;
        end else begin : g_latn
            assign acs_en = vld_q[ACS_LAT-1];
        end
    endgenerate

    assign sm_wr_en   = vld_q[DEPTH-1];
    assign sm_wr_addr = idx_q[DEPTH-1];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame-level sequencer: symbol intake, aligned datapath enables,
// newest-to-oldest traceback over the survivor memory, completion pulse.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int ACS_LAT = ACS_LAT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_in,
    output logic             sym_ready,
    output logic [SYM_W-1:0] bmu_rx,
    output logic             bmu_len,
    output logic             acs_en,
    output logic             sm_wr_en,
    output logic [LEN_W-1:0] sm_wr_addr,
    output logic             tb_en,
    output logic [LEN_W-1:0] tb_addr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] sym_cnt;
    logic [LEN_W-1:0] bmu_idx;
    logic [LEN_W-1:0] last_idx;
    logic             accept;
    logic             start_ok;
    logic             last_acc;
    logic             last_written;

    assign last_idx     = len_q - LEN_W'(1);
    assign accept       = (state == FILL) & sym_valid;
    assign start_ok     = (state == IDLE) & start & (frame_len != '0);
    assign last_acc     = accept & (sym_cnt == last_idx);
    assign last_written = sm_wr_en & (sm_wr_addr == last_idx);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sym_ready = 1'b0;
        tb_en     = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                sym_ready = 1'b1;
                if (last_acc) begin
                    state_nxt = DRAIN;
                end
            end
            // Traceback may only start once the newest survivor has been written.
            DRAIN: begin
                if (last_written) begin
                    state_nxt = TRACE;
                end
            end
            TRACE: begin
                tb_en = 1'b1;
                if (tb_addr == '0) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_q   <= '0;
            sym_cnt <= '0;
            bmu_rx  <= '0;
            bmu_len <= 1'b0;
            bmu_idx <= '0;
            tb_addr <= '0;
            err     <= 1'b0;
        end else begin
            err     <= (state == IDLE) & start & (frame_len == '0);
            bmu_len <= accept;
            if (start_ok) begin
                len_q   <= frame_len;
                sym_cnt <= '0;
            end
            if (accept) begin
                bmu_rx  <= sym_in;
                bmu_idx <= sym_cnt;
                sym_cnt <= sym_cnt + LEN_W'(1);
            end
            if ((state == DRAIN) && last_written) begin
                tb_addr <= last_idx;
            end else if ((state == TRACE) && (tb_addr != '0)) begin
                tb_addr <= tb_addr - LEN_W'(1);
            end
        end
    end

    viterbi_en_pipe #(
        .LEN_W  (LEN_W),
        .ACS_LAT(ACS_LAT)
    ) u_en_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (bmu_len),
        .in_idx    (bmu_idx),
        .acs_en    (acs_en),
        .sm_wr_en  (sm_wr_en),
        .sm_wr_addr(sm_wr_addr)
    );

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl: drives frames and compares
// observed enable/address timelines against a cycle-level reference model.
module tb_viterbi_frame_ctrl;

    localparam int LW  = 8;
    localparam int LAT = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic          sym_valid = 1'b0;
    logic [1:0]    sym_in = '0;
    logic          sym_ready;
    logic [1:0]    bmu_rx;
    logic          bmu_len;
    logic          acs_en;
    logic          sm_wr_en;
    logic [LW-1:0] sm_wr_addr;
    logic          tb_en;
    logic [LW-1:0] tb_addr;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int ev_bmu_c[$], ev_bmu_rx[$], ev_acs_c[$], ev_sm_c[$], ev_sm_a[$];
    int ev_tb_c[$], ev_tb_a[$], ev_done_c[$], ev_err_c[$], ev_busy_c[$], ev_rdy_c[$];

    int sym_q[$], gap_q[$];
    int hs_c[$], hs_s[$];
    int s_cyc;

    viterbi_frame_ctrl #(.LEN_W(LW), .ACS_LAT(LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .frame_len (frame_len),
        .sym_valid (sym_valid),
        .sym_in    (sym_in),
        .sym_ready (sym_ready),
        .bmu_rx    (bmu_rx),
        .bmu_len   (bmu_len),
        .acs_en    (acs_en),
        .sm_wr_en  (sm_wr_en),
        .sm_wr_addr(sm_wr_addr),
        .tb_en     (tb_en),
        .tb_addr   (tb_addr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Observed timeline, sampled mid-cycle; cycle n is the period after the n-th rising edge.
    always @(negedge clock) begin
        if (bmu_len)   begin ev_bmu_c.push_back(cyc); ev_bmu_rx.push_back(int'(bmu_rx)); end
        if (acs_en)    ev_acs_c.push_back(cyc);
        if (sm_wr_en)  begin ev_sm_c.push_back(cyc); ev_sm_a.push_back(int'(sm_wr_addr)); end
        if (tb_en)     begin ev_tb_c.push_back(cyc); ev_tb_a.push_back(int'(tb_addr)); end
        if (done)      ev_done_c.push_back(cyc);
        if (err)       ev_err_c.push_back(cyc);
        if (busy)      ev_busy_c.push_back(cyc);
        if (sym_ready) ev_rdy_c.push_back(cyc);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        ev_bmu_c.delete(); ev_bmu_rx.delete(); ev_acs_c.delete(); ev_sm_c.delete();
        ev_sm_a.delete(); ev_tb_c.delete(); ev_tb_a.delete(); ev_done_c.delete();
        ev_err_c.delete(); ev_busy_c.delete(); ev_rdy_c.delete();
    endtask

    // Starts a frame from IDLE and offers sym_q with gap_q idle cycles before each symbol.
    task automatic drive_frame(input int len);
        hs_c.delete();
        hs_s.delete();
        start     = 1'b1;
        frame_len = LW'(len);
        s_cyc     = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < gap_q[i]; g++) begin
                sym_valid = 1'b0;
                sym_in    = 2'($urandom);
                tick();
            end
            sym_valid = 1'b1;
            sym_in    = 2'(sym_q[i]);
            hs_c.push_back(cyc);
            hs_s.push_back(sym_q[i]);
            tick();
        end
        sym_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        start     = 1'b1;
        sym_valid = 1'b1;
        frame_len = LW'(5);
        sym_in    = 2'd3;
        repeat (3) tick();
        n_checks++;
        if ({sym_ready, bmu_rx, bmu_len, acs_en, sm_wr_en, sm_wr_addr, tb_en, tb_addr, busy, done, err} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {sym_ready, bmu_rx, bmu_len, acs_en, sm_wr_en, sm_wr_addr, tb_en, tb_addr, busy, done, err});
        end
        start     = 1'b0;
        sym_valid = 1'b0;
        reset     = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({busy, sym_ready, tb_en, done, err} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_idle: got %b expected 00000", {busy, sym_ready, tb_en, done, err});
        end
    endtask

    task automatic test_frames();
        int len, t_last, t0, t_done;
        for (int sc = 0; sc < 9; sc++) begin
            sym_q.delete();
            gap_q.delete();
            case (sc)
                0: begin len = 4; for (int i = 0; i < 4; i++) begin sym_q.push_back(i); gap_q.push_back(0); end end
                1: begin len = 3; for (int i = 0; i < 3; i++) begin sym_q.push_back(3 - i); gap_q.push_back(i == 2 ? 2 : 0); end end
                2: begin len = 1; sym_q.push_back(2); gap_q.push_back(0); end
                default: begin
                    len = int'($urandom_range(1, 12));
                    for (int i = 0; i < len; i++) begin
                        sym_q.push_back(int'($urandom_range(0, 3)));
                        gap_q.push_back(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0);
                    end
                end
            endcase
            clear_mon();
            drive_frame(len);
            t_last = hs_c[len-1];
            t0     = t_last + 3 + LAT;
            t_done = t0 + len;
            while (cyc < t_done + 2) begin
                sym_valid = (sc >= 3) ? 1'($urandom) : 1'b0;
                sym_in    = 2'($urandom);
                tick();
            end
            sym_valid = 1'b0;

            n_checks++;
            if (ev_bmu_c.size() !== len) begin n_fail++; $display("[TB] FAIL f%0d bmu_count: got %0d expected %0d", sc, ev_bmu_c.size(), len); end
            else for (int i = 0; i < len; i++) begin
                n_checks++;
                if (ev_bmu_c[i] !== hs_c[i] + 1 || ev_bmu_rx[i] !== hs_s[i]) begin
                    n_fail++;
                    $display("[TB] FAIL f%0d bmu[%0d]: got cyc %0d rx %0d expected cyc %0d rx %0d", sc, i, ev_bmu_c[i], ev_bmu_rx[i], hs_c[i] + 1, hs_s[i]);
                end
            end
            n_checks++;
            if (ev_acs_c.size() !== len) begin n_fail++; $display("[TB] FAIL f%0d acs_count: got %0d expected %0d", sc, ev_acs_c.size(), len); end
            else for (int i = 0; i < len; i++) begin
                n_checks++;
                if (ev_acs_c[i] !== hs_c[i] + 1 + LAT) begin
                    n_fail++;
                    $display("[TB] FAIL f%0d acs[%0d]: got cyc %0d expected cyc %0d", sc, i, ev_acs_c[i], hs_c[i] + 1 + LAT);
                end
            end
            n_checks++;
            if (ev_sm_c.size() !== len) begin n_fail++; $display("[TB] FAIL f%0d sm_count: got %0d expected %0d", sc, ev_sm_c.size(), len); end
            else for (int i = 0; i < len; i++) begin
                n_checks++;
                if (ev_sm_c[i] !== hs_c[i] + 2 + LAT || ev_sm_a[i] !== i) begin
                    n_fail++;
                    $display("[TB] FAIL f%0d sm[%0d]: got cyc %0d addr %0d expected cyc %0d addr %0d", sc, i, ev_sm_c[i], ev_sm_a[i], hs_c[i] + 2 + LAT, i);
                end
            end
            n_checks++;
            if (ev_tb_c.size() !== len) begin n_fail++; $display("[TB] FAIL f%0d tb_count: got %0d expected %0d", sc, ev_tb_c.size(), len); end
            else for (int i = 0; i < len; i++) begin
                n_checks++;
                if (ev_tb_c[i] !== t0 + i || ev_tb_a[i] !== len - 1 - i) begin
                    n_fail++;
                    $display("[TB] FAIL f%0d tb[%0d]: got cyc %0d addr %0d expected cyc %0d addr %0d", sc, i, ev_tb_c[i], ev_tb_a[i], t0 + i, len - 1 - i);
                end
            end
            n_checks++;
            if (ev_done_c.size() !== 1 || ev_done_c[0] !== t_done) begin
                n_fail++;
                $display("[TB] FAIL f%0d done: got %0d pulses (first cyc %0d) expected 1 at cyc %0d", sc, ev_done_c.size(), (ev_done_c.size() > 0) ? ev_done_c[0] : -1, t_done);
            end
            n_checks++;
            if (ev_busy_c.size() !== t_done - s_cyc || ev_busy_c[0] !== s_cyc + 1 || ev_busy_c[ev_busy_c.size()-1] !== t_done) begin
                n_fail++;
                $display("[TB] FAIL f%0d busy_window: got %0d cycles expected %0d cycles from %0d to %0d", sc, ev_busy_c.size(), t_done - s_cyc, s_cyc + 1, t_done);
            end
            n_checks++;
            if (ev_rdy_c.size() !== t_last - s_cyc || ev_rdy_c[0] !== s_cyc + 1) begin
                n_fail++;
                $display("[TB] FAIL f%0d ready_window: got %0d cycles expected %0d from cyc %0d", sc, ev_rdy_c.size(), t_last - s_cyc, s_cyc + 1);
            end
            n_checks++;
            if (ev_err_c.size() !== 0) begin n_fail++; $display("[TB] FAIL f%0d err: got %0d pulses expected 0", sc, ev_err_c.size()); end
        end
    endtask

    task automatic test_zero_len();
        int c;
        clear_mon();
        start     = 1'b1;
        frame_len = '0;
        c         = cyc;
        tick();
        start = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (ev_err_c.size() !== 1 || ev_err_c[0] !== c + 1) begin
            n_fail++;
            $display("[TB] FAIL zero_len_err: got %0d pulses expected 1 at cyc %0d", ev_err_c.size(), c + 1);
        end
        n_checks++;
        if (ev_busy_c.size() !== 0 || ev_rdy_c.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL zero_len_busy: got busy %0d ready %0d cycles expected 0 and 0", ev_busy_c.size(), ev_rdy_c.size());
        end
    endtask

    task automatic test_start_while_busy();
        int t_last, t0, t_done;
        sym_q.delete();
        gap_q.delete();
        for (int i = 0; i < 5; i++) begin sym_q.push_back(int'($urandom_range(0, 3))); gap_q.push_back(0); end
        clear_mon();
        drive_frame(5);
        t_last = hs_c[4];
        t0     = t_last + 3 + LAT;
        t_done = t0 + 5;
        while (cyc < t0 + 1) tick();
        start     = 1'b1;
        frame_len = LW'(9);
        tick();
        start = 1'b0;
        while (cyc < t_done + 4) tick();
        n_checks++;
        if (ev_tb_c.size() !== 5) begin n_fail++; $display("[TB] FAIL busy_start tb_count: got %0d expected 5", ev_tb_c.size()); end
        else for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (ev_tb_a[i] !== 4 - i || ev_tb_c[i] !== t0 + i) begin
                n_fail++;
                $display("[TB] FAIL busy_start tb[%0d]: got cyc %0d addr %0d expected cyc %0d addr %0d", i, ev_tb_c[i], ev_tb_a[i], t0 + i, 4 - i);
            end
        end
        n_checks++;
        if (ev_done_c.size() !== 1 || ev_done_c[0] !== t_done) begin
            n_fail++;
            $display("[TB] FAIL busy_start done: got %0d pulses expected 1 at cyc %0d", ev_done_c.size(), t_done);
        end
        n_checks++;
        if (ev_busy_c.size() !== t_done - s_cyc || ev_err_c.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL busy_start ignored: got busy %0d err %0d expected busy %0d err 0", ev_busy_c.size(), ev_err_c.size(), t_done - s_cyc);
        end
    endtask

    task automatic test_reset_mid_fill();
        int t_done;
        clear_mon();
        start     = 1'b1;
        frame_len = LW'(6);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sym_valid = 1'b1;
            sym_in    = 2'(i + 1);
            tick();
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({sym_ready, bmu_rx, bmu_len, acs_en, sm_wr_en, sm_wr_addr, tb_en, tb_addr, busy, done, err} !== '0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_outputs: got %h expected 0",
                     {sym_ready, bmu_rx, bmu_len, acs_en, sm_wr_en, sm_wr_addr, tb_en, tb_addr, busy, done, err});
        end
        sym_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (12) tick();
        n_checks++;
        if (ev_done_c.size() !== 0 || ev_tb_c.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_no_done: got done %0d tb %0d expected 0 and 0", ev_done_c.size(), ev_tb_c.size());
        end
        sym_q.delete();
        gap_q.delete();
        for (int i = 0; i < 3; i++) begin sym_q.push_back(int'($urandom_range(0, 3))); gap_q.push_back(0); end
        clear_mon();
        drive_frame(3);
        t_done = hs_c[2] + 3 + LAT + 3;
        while (cyc < t_done + 2) tick();
        n_checks++;
        if (ev_sm_c.size() !== 3 || ev_sm_a[0] !== 0 || ev_sm_a[2] !== 2) begin
            n_fail++;
            $display("[TB] FAIL after_reset writes: got %0d writes expected 3 at addr 0..2", ev_sm_c.size());
        end
        n_checks++;
        if (ev_done_c.size() !== 1 || ev_done_c[0] !== t_done || ev_tb_c.size() !== 3) begin
            n_fail++;
            $display("[TB] FAIL after_reset done: got %0d pulses, %0d tb cycles expected 1 at cyc %0d, 3 tb cycles", ev_done_c.size(), ev_tb_c.size(), t_done);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_zero_len();
        test_start_while_busy();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
